// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and widths for the truth-table sweeper.
// Encodings come from sweep_defs.vh so non-SV consumers see the same values.
package truth_table_sweeper_pkg;

    `include "sweep_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE   = `SWEEP_ST_IDLE,
        ST_SETTLE = `SWEEP_ST_SETTLE,
        ST_SAMPLE = `SWEEP_ST_SAMPLE,
        ST_DONE   = `SWEEP_ST_DONE
    } state_t;

    localparam int N_VEC = `SWEEP_N_VEC;
    localparam int IDX_W = `SWEEP_IDX_W;
    localparam int CNT_W = 4;
    localparam int FC_W  = 5;

endpackage

// File: rtl/sweep_defs.vh
`ifndef SWEEP_DEFS_VH
`define SWEEP_DEFS_VH

`define SWEEP_ST_IDLE   2'd0
`define SWEEP_ST_SETTLE 2'd1
`define SWEEP_ST_SAMPLE 2'd2
`define SWEEP_ST_DONE   2'd3

`define SWEEP_N_VEC     16
`define SWEEP_IDX_W     4

`endif

// File: rtl/sweep_settle_timer.sv
// Down-counter that paces each vector's settle window; load wins over decrement.
// Latency: zero reflects the registered count; no backpressure, free-running on dec.
module sweep_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors into an external datapath and checks f/g against EXP_F/EXP_G.
// Latency: SETTLE_CYC+1 cycles per vector; start is ignored while a sweep is running.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int          SETTLE_CYC = 2,
    parameter logic [15:0] EXP_F      = 16'h0000,
    parameter logic [15:0] EXP_G      = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    input  logic       g_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] first_fail_idx
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [FC_W-1:0]  fc_q;
    logic [IDX_W-1:0] ffi_q;

    logic t_load, t_dec, t_zero;
    logic begin_sweep, advance, mismatch;

    sweep_settle_timer #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (CNT_W'(SETTLE_CYC - 1)),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        t_load      = 1'b0;
        t_dec       = 1'b0;
        begin_sweep = 1'b0;
        advance     = 1'b0;
        mismatch    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    begin_sweep = 1'b1;
                    t_load      = 1'b1;
                end
            end
            ST_SETTLE: begin
                t_dec = 1'b1;
                if (t_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // Either output wrong counts as a single failure for this vector.
                mismatch = (f_in != EXP_F[idx_q]) || (g_in != EXP_G[idx_q]);
                if (idx_q == IDX_W'(N_VEC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                    advance = 1'b1;
                    t_load  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            fc_q  <= '0;
            ffi_q <= '0;
        end else if (begin_sweep) begin
            idx_q <= '0;
            fc_q  <= '0;
            ffi_q <= '0;
        end else begin
            if (advance) begin
                idx_q <= idx_q + 1'b1;
            end
            if (mismatch) begin
                fc_q <= fc_q + 1'b1;
                if (fc_q == '0) begin
                    ffi_q <= idx_q;
                end
            end
        end
    end

    assign {a, b, c, d}   = idx_q;
    assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && (fc_q == '0);
    assign fail_count     = fc_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Four sweepers: 0 good table, 1 table wrong at vector 0, 2 f stuck-at-0 vs all-ones table, 3 SETTLE_CYC=1.
module tb_truth_table_sweeper;

    typedef struct {
        logic [4:0] fc;
        logic [3:0] ffi;
        logic       pass;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_v;

    logic [3:0] abcd_w [4];
    logic       busy_w [4];
    logic       done_w [4];
    logic       pass_w [4];
    logic [4:0] fc_w   [4];
    logic [3:0] ffi_w  [4];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int          SC = (k == 3) ? 1 : 2;
        localparam logic [15:0] EF = (k == 1) ? 16'h6997 : (k == 2) ? 16'hFFFF : 16'h6996;
        localparam logic [15:0] EG = (k == 2) ? 16'h0000 : 16'h8000;
        logic a_l, b_l, c_l, d_l, busy_l, done_l, pass_l, f_l, g_l;
        logic [4:0] fc_l;
        logic [3:0] ffi_l;

        assign f_l = (k == 2) ? 1'b0 : (a_l ^ b_l ^ c_l ^ d_l);
        assign g_l = (k == 2) ? 1'b0 : (a_l & b_l & c_l & d_l);

        truth_table_sweeper #(.SETTLE_CYC(SC), .EXP_F(EF), .EXP_G(EG)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start_v[k]),
            .f_in           (f_l),
            .g_in           (g_l),
            .a              (a_l),
            .b              (b_l),
            .c              (c_l),
            .d              (d_l),
            .busy           (busy_l),
            .done           (done_l),
            .pass           (pass_l),
            .fail_count     (fc_l),
            .first_fail_idx (ffi_l)
        );

        assign abcd_w[k] = {a_l, b_l, c_l, d_l};
        assign busy_w[k] = busy_l;
        assign done_w[k] = done_l;
        assign pass_w[k] = pass_l;
        assign fc_w[k]   = fc_l;
        assign ffi_w[k]  = ffi_l;
    end

    int         checks = 0;
    int         errors = 0;
    res_t       exp_q[$];
    logic [3:0] vec_exp_q[$];
    logic [3:0] seen_vec[$];
    int         seen_len[$];
    int         sweep_cycles;
    bit         timed_out;

    // Independent reference: evaluates the intended datapath over all 16 vectors.
    function automatic res_t model(logic [15:0] ef, logic [15:0] eg, bit stuck);
        res_t r;
        r.fc  = '0;
        r.ffi = '0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            logic fv, gv;
            v  = 4'(i);
            fv = stuck ? 1'b0 : ^v;
            gv = stuck ? 1'b0 : &v;
            if (fv !== ef[i] || gv !== eg[i]) begin
                if (r.fc == 0) r.ffi = v;
                r.fc = r.fc + 1'b1;
            end
        end
        r.pass = (r.fc == 0);
        return r;
    endfunction

    task automatic kick(input int k, input res_t r);
        @(negedge clk);
        start_v[k] = 1'b1;
        exp_q.push_back(r);
        vec_exp_q.delete();
        for (int i = 0; i < 16; i++) vec_exp_q.push_back(4'(i));
    endtask

    task automatic record(input int k);
        if (busy_w[k]) begin
            if (seen_vec.size() == 0 || abcd_w[k] != seen_vec[seen_vec.size()-1]) begin
                seen_vec.push_back(abcd_w[k]);
                seen_len.push_back(1);
            end else begin
                seen_len[seen_len.size()-1] = seen_len[seen_len.size()-1] + 1;
            end
        end
    endtask

    // Follows one sweep from its start edge to done; optionally toggles start while busy.
    task automatic watch(input int k, input bit toggle);
        seen_vec.delete();
        seen_len.delete();
        timed_out    = 1'b0;
        sweep_cycles = 0;
        @(posedge clk);
        #1;
        start_v[k] = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        record(k);
        while (1) begin
            @(posedge clk);
            #1;
            sweep_cycles++;
            if (done_w[k]) break;
            if (sweep_cycles > 200) begin
                timed_out = 1'b1;
                break;
            end
            start_v[k] = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            record(k);
        end
        start_v[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({abcd_w[k], busy_w[k], done_w[k], pass_w[k], fc_w[k], ffi_w[k]} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h want 0", k,
                         {abcd_w[k], busy_w[k], done_w[k], pass_w[k], fc_w[k], ffi_w[k]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_sweep;
        res_t r;
        kick(0, model(16'h6996, 16'h8000, 1'b0));
        watch(0, 1'b1);
        checks++;
        if (timed_out || sweep_cycles !== 48) begin
            errors++;
            $display("FAIL pass_latency got %0d want 48 (timeout=%0d)", sweep_cycles, timed_out);
        end
        checks++;
        if (seen_vec.size() !== 16) begin
            errors++;
            $display("FAIL pass_vec_count got %0d want 16", seen_vec.size());
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            e = vec_exp_q.pop_front();
            checks++;
            if (i >= seen_vec.size() || seen_vec[i] !== e || seen_len[i] !== 3) begin
                errors++;
                $display("FAIL pass_vec[%0d] got %h/%0d want %h/3", i,
                         (i < seen_vec.size()) ? seen_vec[i] : 4'hx,
                         (i < seen_len.size()) ? seen_len[i] : -1, e);
            end
        end
        r = exp_q.pop_front();
        checks++;
        if (done_w[0] !== 1'b1 || pass_w[0] !== r.pass || fc_w[0] !== r.fc || ffi_w[0] !== r.ffi) begin
            errors++;
            $display("FAIL pass_result got d%0b p%0b fc%0d ff%0d want d1 p%0b fc%0d ff%0d",
                     done_w[0], pass_w[0], fc_w[0], ffi_w[0], r.pass, r.fc, r.ffi);
        end
    endtask

    task automatic test_restart_in_done;
        int n;
        @(negedge clk);
        checks++;
        if (done_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre_done got %b want 1", done_w[0]);
        end
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1 || abcd_w[0] !== 4'h0 || fc_w[0] !== 5'd0) begin
            errors++;
            $display("FAIL restart_next got d%0b b%0b v%h fc%0d want d0 b1 v0 fc0",
                     done_w[0], busy_w[0], abcd_w[0], fc_w[0]);
        end
        start_v[0] = 1'b0;
        n = 0;
        while (!done_w[0] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 48 || pass_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_complete got %0d cycles pass %b want 48 pass 1", n, pass_w[0]);
        end
    endtask

    task automatic test_fail_sweep(input int k, input logic [15:0] ef, input logic [15:0] eg,
                                   input bit stuck, input logic [4:0] want_fc);
        res_t r;
        kick(k, model(ef, eg, stuck));
        watch(k, 1'b0);
        r = exp_q.pop_front();
        checks++;
        if (timed_out || sweep_cycles !== 48) begin
            errors++;
            $display("FAIL fail_latency dut%0d got %0d want 48", k, sweep_cycles);
        end
        checks++;
        if (r.fc !== want_fc || fc_w[k] !== r.fc) begin
            errors++;
            $display("FAIL fail_count dut%0d got %0d want %0d", k, fc_w[k], want_fc);
        end
        checks++;
        if (ffi_w[k] !== r.ffi || pass_w[k] !== 1'b0 || done_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL fail_result dut%0d got ff%0d p%0b d%0b want ff%0d p0 d1",
                     k, ffi_w[k], pass_w[k], done_w[k], r.ffi);
        end
    endtask

    task automatic test_reset_mid_sweep;
        res_t r;
        int   n;
        kick(0, model(16'h6996, 16'h8000, 1'b0));
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        n = 0;
        while (abcd_w[0] !== 4'h7 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (abcd_w[0] !== 4'h7) begin
            errors++;
            $display("FAIL mid_reach_7 got %h want 7", abcd_w[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({abcd_w[0], busy_w[0], done_w[0], pass_w[0], fc_w[0], ffi_w[0]} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_clear got %h want 0",
                     {abcd_w[0], busy_w[0], done_w[0], pass_w[0], fc_w[0], ffi_w[0]});
        end
        void'(exp_q.pop_front());
        vec_exp_q.delete();
        repeat (2) @(posedge clk);
        // Release together with start: the release edge itself must launch the sweep.
        @(negedge clk);
        rst_n      = 1'b1;
        start_v[0] = 1'b1;
        exp_q.push_back(model(16'h6996, 16'h8000, 1'b0));
        for (int i = 0; i < 16; i++) vec_exp_q.push_back(4'(i));
        watch(0, 1'b0);
        checks++;
        if (timed_out || sweep_cycles !== 48 || seen_vec.size() !== 16) begin
            errors++;
            $display("FAIL mid_resweep got %0d cycles %0d vecs want 48/16", sweep_cycles, seen_vec.size());
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            e = vec_exp_q.pop_front();
            checks++;
            if (i >= seen_vec.size() || seen_vec[i] !== e || seen_len[i] !== 3) begin
                errors++;
                $display("FAIL mid_vec[%0d] want %h/3", i, e);
            end
        end
        r = exp_q.pop_front();
        checks++;
        if (pass_w[0] !== r.pass || fc_w[0] !== r.fc || ffi_w[0] !== r.ffi) begin
            errors++;
            $display("FAIL mid_result got p%0b fc%0d ff%0d want p%0b fc%0d ff%0d",
                     pass_w[0], fc_w[0], ffi_w[0], r.pass, r.fc, r.ffi);
        end
    endtask

    task automatic test_settle_one;
        res_t r;
        kick(3, model(16'h6996, 16'h8000, 1'b0));
        watch(3, 1'b0);
        checks++;
        if (timed_out || sweep_cycles !== 32 || seen_vec.size() !== 16) begin
            errors++;
            $display("FAIL s1_latency got %0d cycles %0d vecs want 32/16", sweep_cycles, seen_vec.size());
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            e = vec_exp_q.pop_front();
            checks++;
            if (i >= seen_vec.size() || seen_vec[i] !== e || seen_len[i] !== 2) begin
                errors++;
                $display("FAIL s1_vec[%0d] got %h/%0d want %h/2", i,
                         (i < seen_vec.size()) ? seen_vec[i] : 4'hx,
                         (i < seen_len.size()) ? seen_len[i] : -1, e);
            end
        end
        r = exp_q.pop_front();
        checks++;
        if (pass_w[3] !== r.pass || fc_w[3] !== r.fc) begin
            errors++;
            $display("FAIL s1_result got p%0b fc%0d want p%0b fc%0d", pass_w[3], fc_w[3], r.pass, r.fc);
        end
    endtask

    initial begin
        test_reset();
        test_pass_sweep();
        test_restart_in_done();
        test_fail_sweep(1, 16'h6997, 16'h8000, 1'b0, 5'd1);
        test_fail_sweep(2, 16'hFFFF, 16'h0000, 1'b1, 5'd16);
        test_reset_mid_sweep();
        test_settle_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of cycles each input vector is held before sampling; legal range 1..15.
REQ-002 Parameter EXP_F, default 16'h0000, expected f truth table; bit i is the expected f for vector i = {a,b,c,d}.
REQ-003 Parameter EXP_G, default 16'h0000, expected g truth table, same indexing as EXP_F.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  begin a sweep; sampled only in IDLE and DONE.
REQ-007 f_in  input  1  f output of the 4-input datapath under test.
REQ-008 g_in  input  1  g output of the 4-input datapath under test.
REQ-009 a, b, c, d  output  1 each  registered datapath inputs; {a,b,c,d} = current vector index, a is the MSB.
REQ-010 busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE).
REQ-011 done  output  1  high in DONE; held until the next start or reset.
REQ-012 pass  output  1  high in DONE when fail_count == 0; low otherwise.
REQ-013 fail_count  output  5  number of mismatching vectors in the current or last sweep (0..16).
REQ-014 first_fail_idx  output  4  index of the first mismatching vector; 4'h0 if there is none.

Function
REQ-015 The FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE or DONE with start=1: next state SETTLE; idx=0; fail_count=0; first_fail_idx=0; settle counter=SETTLE_CYC-1; done=0.
REQ-017 SETTLE: the settle counter decrements each cycle; when it is 0, next state is SAMPLE.
REQ-018 SAMPLE: compare f_in with EXP_F[idx] and g_in with EXP_G[idx]; a mismatch on either output counts as one failure for that vector.
REQ-019 On a failure, fail_count increments by 1; first_fail_idx is loaded with idx only if fail_count was 0.
REQ-020 SAMPLE with idx < 15: increment idx, reload the settle counter, next state SETTLE.
REQ-021 SAMPLE with idx == 15: next state DONE; idx holds at 15 and does not wrap.
REQ-022 Each vector occupies exactly SETTLE_CYC+1 cycles; done rises 16*(SETTLE_CYC+1) cycles after the first SETTLE cycle.
REQ-023 start in SETTLE or SAMPLE SHALL be ignored; a sweep cannot be restarted mid-run.
REQ-024 start held high in DONE SHALL begin a new sweep on the next edge; done falls in the same cycle.
REQ-025 a, b, c, d SHALL change only on the SAMPLE->SETTLE transition and on sweep start, never during SETTLE.
REQ-026 fail_count is 5 bits wide so that 16 failures do not overflow; pass is a combinational decode of (state==DONE && fail_count==0).

Reset
REQ-027 While rst_n is low, all outputs and state SHALL clear immediately: state=IDLE, a=b=c=d=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no residual results; the first start after release begins at idx 0.
REQ-029 Reset release SHALL take effect on the next rising edge of clk; start sampled on that edge is honoured.

Structure
REQ-030 State encodings (2-bit), the vector count (16) and the idx width (4) SHALL live in the shared include file sweep_defs.vh.
REQ-031 The settle counter SHALL be the sub-module sweep_settle_timer, with load, load value, count-down and zero-flag ports.
REQ-032 The comparison and result registers SHALL reside in truth_table_sweeper; the datapath under test is external and is not instantiated.

Verification
REQ-033 Datapath f=a^b^c^d, g=a&b&c&d, EXP_F=16'h6996, EXP_G=16'h8000, SETTLE_CYC=2, one start pulse -> done after 48 cycles, pass=1, fail_count=0.
REQ-034 Same setup with EXP_F=16'h6997 -> done=1, pass=0, fail_count=1, first_fail_idx=0.
REQ-035 f stuck at 0, EXP_F=16'hFFFF, EXP_G=16'h0000 with g=0 -> fail_count=16 (5'h10), first_fail_idx=0, pass=0.
REQ-036 rst_n pulsed low while idx=7 -> all outputs 0 immediately; a new start completes a full, correct 16-vector sweep.
REQ-037 start toggled during SETTLE and SAMPLE -> idx sequence 0..15 is unaffected; a start held in DONE restarts with done low the next cycle.
REQ-038 SETTLE_CYC=1 -> each vector is held 2 cycles; the bench checks {a,b,c,d} is stable for exactly 2 cycles at every index.
